// File: rtl/btb_assoc.sv
// btb_assoc: 2-way set-associative branch target buffer with per-entry
// saturating direction counters, per-set LRU replacement and a multi-cycle
// flush engine that walks one set per cycle.
//
// Ports:
//   CLK, RSTn                  clock (posedge) / async active-low reset
//   rd_idx, rd_tag             combinational lookup request
//   found, taken, btbOut       lookup result (all zero on miss or while busy)
//   upd_valid, upd_idx, upd_tag, upd_target, upd_taken
//                              resolved-branch commit, applied on posedge
//   flush                      single-cycle pulse starting a table flush
//   busy                       flush in progress (lookups/commits suppressed)
//
// Optional feature, macro BTB_PERF_EN: adds 32-bit counters upd_cnt,
// upd_hit_cnt and mispred_cnt (reset to 0, cleared on flush acceptance).
//
// State | meaning
// ------+----------------------------------------------------
// IDLE  | normal operation, lookups and commits accepted
// FLUSH | clearing set[ptr_q] each cycle, busy=1

module btb_assoc #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 6,
  parameter int TGT_W = 32,
  parameter int CTR_W = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             found,
  output logic             taken,
  output logic [31:0]      btbOut,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [31:0]      upd_target,
  input  logic             upd_taken,
  input  logic             flush,
  output logic             busy
`ifdef BTB_PERF_EN
  ,
  output logic [31:0]      upd_cnt,
  output logic [31:0]      upd_hit_cnt,
  output logic [31:0]      mispred_cnt
`endif
);

  localparam int SETS = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             flush_acc;
  logic             clear_en;

  logic             valid_q [SETS][2];
  logic [TAG_W-1:0] tag_q   [SETS][2];
  logic [CTR_W-1:0] ctr_q   [SETS][2];
  logic [TGT_W-1:0] tgt_q   [SETS][2];
  logic             lru_q   [SETS];

  // ---------------- flush FSM ----------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    flush_acc = 1'b0;
    clear_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d   = S_FLUSH;
          ptr_d     = '0;
          flush_acc = 1'b1;
        end
      end
      S_FLUSH: begin
        clear_en = 1'b1;
        if (ptr_q == LAST_SET) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_FLUSH);

  // ---------------- lookup ----------------
  logic rh0, rh1, rd_way, rd_hit;

  assign rh0    = valid_q[rd_idx][0] && (tag_q[rd_idx][0] == rd_tag);
  assign rh1    = valid_q[rd_idx][1] && (tag_q[rd_idx][1] == rd_tag);
  assign rd_way = !rh0;  // way 0 wins when both ways match
  assign rd_hit = (rh0 || rh1) && !busy;

  assign found  = rd_hit;
  assign taken  = rd_hit && ctr_q[rd_idx][rd_way][CTR_W-1];
  assign btbOut = rd_hit ? 32'(tgt_q[rd_idx][rd_way]) : 32'd0;

  // ---------------- commit ----------------
  logic             commit;
  logic             uh0, uh1, u_hit, u_way, victim;
  logic [CTR_W-1:0] u_ctr, ctr_next;

  // A flush request in the same cycle wins over a commit.
  assign commit = upd_valid && !busy && !flush;

  assign uh0   = valid_q[upd_idx][0] && (tag_q[upd_idx][0] == upd_tag);
  assign uh1   = valid_q[upd_idx][1] && (tag_q[upd_idx][1] == upd_tag);
  assign u_hit = uh0 || uh1;
  assign u_way = !uh0;
  assign u_ctr = ctr_q[upd_idx][u_way];

  always_comb begin
    ctr_next = u_ctr;
    if (upd_taken) begin
      if (u_ctr != CTR_MAX) ctr_next = u_ctr + CTR_W'(1);
    end else begin
      if (u_ctr != '0) ctr_next = u_ctr - CTR_W'(1);
    end
  end

  // Fill an empty way first; only evict the LRU way when both are valid.
  always_comb begin
    if (!valid_q[upd_idx][0])      victim = 1'b0;
    else if (!valid_q[upd_idx][1]) victim = 1'b1;
    else                           victim = lru_q[upd_idx];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          ctr_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
        end
      end
    end else if (clear_en) begin
      valid_q[ptr_q][0] <= 1'b0;
      valid_q[ptr_q][1] <= 1'b0;
      ctr_q[ptr_q][0]   <= '0;
      ctr_q[ptr_q][1]   <= '0;
      lru_q[ptr_q]      <= 1'b0;
    end else if (commit) begin
      if (u_hit) begin
        ctr_q[upd_idx][u_way] <= ctr_next;
        if (upd_taken) tgt_q[upd_idx][u_way] <= upd_target[TGT_W-1:0];
        lru_q[upd_idx] <= ~u_way;
      end else if (upd_taken) begin
        valid_q[upd_idx][victim] <= 1'b1;
        tag_q[upd_idx][victim]   <= upd_tag;
        tgt_q[upd_idx][victim]   <= upd_target[TGT_W-1:0];
        ctr_q[upd_idx][victim]   <= CTR_WEAK;
        lru_q[upd_idx]           <= ~victim;
      end
    end
  end

`ifdef BTB_PERF_EN
  // ---------------- performance counters ----------------
  logic mispred;

  // Prediction as the fetch stage would have seen it before this commit.
  assign mispred = u_hit ? ((u_ctr[CTR_W-1] != upd_taken) ||
                            (upd_taken && (tgt_q[upd_idx][u_way] != upd_target[TGT_W-1:0])))
                         : upd_taken;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      upd_cnt     <= '0;
      upd_hit_cnt <= '0;
      mispred_cnt <= '0;
    end else if (flush_acc) begin
      upd_cnt     <= '0;
      upd_hit_cnt <= '0;
      mispred_cnt <= '0;
    end else if (commit) begin
      upd_cnt <= upd_cnt + 32'd1;
      if (u_hit)   upd_hit_cnt <= upd_hit_cnt + 32'd1;
      if (mispred) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: scoreboard bench for btb_assoc. Each stimulus cycle pushes the
// expected lookup result (from a table-level reference model) into a queue; a
// monitor on the falling edge pops and compares against the DUT outputs.

module tb_btb_assoc;

  localparam int IDX_W    = 4;
  localparam int TAG_W    = 6;
  localparam int TGT_W    = 32;
  localparam int CTR_W    = 2;
  localparam int SETS     = 1 << IDX_W;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int CTR_WEAK = 1 << (CTR_W - 1);

  logic             CLK = 1'b0;
  logic             RSTn;
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             found, taken, busy;
  logic [31:0]      btbOut;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic             flush;
`ifdef BTB_PERF_EN
  logic [31:0] upd_cnt, upd_hit_cnt, mispred_cnt;
`endif

  btb_assoc #(.IDX_W(IDX_W), .TAG_W(TAG_W), .TGT_W(TGT_W), .CTR_W(CTR_W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .rd_idx(rd_idx), .rd_tag(rd_tag),
    .found(found), .taken(taken), .btbOut(btbOut),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_tag(upd_tag),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .flush(flush), .busy(busy)
`ifdef BTB_PERF_EN
    , .upd_cnt(upd_cnt), .upd_hit_cnt(upd_hit_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  bit          m_valid [SETS][2];
  int          m_tag   [SETS][2];
  int          m_ctr   [SETS][2];
  logic [31:0] m_tgt   [SETS][2];
  int          m_lru   [SETS];
  int          m_flush_left;
  logic [31:0] m_cnt, m_hit, m_mis;

  typedef struct {
    string       name;
    logic        found;
    logic        taken;
    logic [31:0] tgt;
    logic        busy;
    logic [31:0] c0, c1, c2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = 0; m_ctr[s][w] = 0; m_tgt[s][w] = '0;
      end
    end
    m_flush_left = 0;
    m_cnt = '0; m_hit = '0; m_mis = '0;
  endfunction

  function automatic int model_find(int s, int t);
    if (m_valid[s][0] && m_tag[s][0] == t) return 0;
    if (m_valid[s][1] && m_tag[s][1] == t) return 1;
    return -1;
  endfunction

  function automatic exp_t model_lookup(string nm);
    exp_t e;
    int   w;
    int   s;
    s = int'(rd_idx);
    e.name = nm; e.found = 0; e.taken = 0; e.tgt = '0;
    e.busy = RSTn && (m_flush_left > 0);
    w = -1;
    if (RSTn && m_flush_left == 0) w = model_find(s, int'(rd_tag));
    if (w >= 0) begin
      e.found = 1;
      e.taken = (m_ctr[s][w] >= CTR_WEAK);
      e.tgt   = m_tgt[s][w];
    end
    e.c0 = m_cnt; e.c1 = m_hit; e.c2 = m_mis;
    return e;
  endfunction

  function automatic void model_edge();
    int s, w, v, p;
    if (!RSTn) begin
      model_reset();
      return;
    end
    if (m_flush_left > 0) begin
      p = SETS - m_flush_left;
      m_valid[p][0] = 0; m_valid[p][1] = 0;
      m_ctr[p][0] = 0;   m_ctr[p][1] = 0;
      m_lru[p] = 0;
      m_flush_left--;
    end else if (flush) begin
      m_flush_left = SETS;
      m_cnt = '0; m_hit = '0; m_mis = '0;
    end else if (upd_valid) begin
      s = int'(upd_idx);
      w = model_find(s, int'(upd_tag));
      m_cnt = m_cnt + 1;
      if (w >= 0) begin
        m_hit = m_hit + 1;
        if ((m_ctr[s][w] >= CTR_WEAK) != upd_taken ||
            (upd_taken && m_tgt[s][w] != upd_target)) m_mis = m_mis + 1;
        if (upd_taken) begin
          if (m_ctr[s][w] < CTR_MAX) m_ctr[s][w]++;
          m_tgt[s][w] = upd_target;
        end else if (m_ctr[s][w] > 0) begin
          m_ctr[s][w]--;
        end
        m_lru[s] = 1 - w;
      end else if (upd_taken) begin
        m_mis = m_mis + 1;
        if (!m_valid[s][0])      v = 0;
        else if (!m_valid[s][1]) v = 1;
        else                     v = m_lru[s];
        m_valid[s][v] = 1; m_tag[s][v] = int'(upd_tag);
        m_tgt[s][v] = upd_target; m_ctr[s][v] = CTR_WEAK;
        m_lru[s] = 1 - v;
      end
    end
  endfunction

  // ---------------- stimulus ----------------
  // Called at posedge+1; drives one cycle of inputs, queues the expectation,
  // then advances the model across the next edge.
  task automatic step(input string nm, input int ridx, input int rtag,
                      input bit uv, input int uidx, input int utag,
                      input logic [31:0] utgt, input bit ut, input bit fl);
    rd_idx     = ridx[IDX_W-1:0];
    rd_tag     = rtag[TAG_W-1:0];
    upd_valid  = uv;
    upd_idx    = uidx[IDX_W-1:0];
    upd_tag    = utag[TAG_W-1:0];
    upd_target = utgt;
    upd_taken  = ut;
    flush      = fl;
    sb.push_back(model_lookup(nm));
    chk_en = 1'b1;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic look(input string nm, input int ridx, input int rtag);
    step(nm, ridx, rtag, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic commit(input string nm, input int idx, input int tag,
                        input logic [31:0] tgt, input bit tk);
    step(nm, idx, tag, 1, idx, tag, tgt, tk, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    exp_t e;
    if (chk_en) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if ({found, taken, btbOut, busy} !== {e.found, e.taken, e.tgt, e.busy}) begin
          n_bad++;
          $display("FAIL %s: got found=%0b taken=%0b btbOut=%h busy=%0b, expected found=%0b taken=%0b btbOut=%h busy=%0b",
                   e.name, found, taken, btbOut, busy, e.found, e.taken, e.tgt, e.busy);
        end
`ifdef BTB_PERF_EN
        n_cmp++;
        if ({upd_cnt, upd_hit_cnt, mispred_cnt} !== {e.c0, e.c1, e.c2}) begin
          n_bad++;
          $display("FAIL %s_perf: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                   e.name, upd_cnt, upd_hit_cnt, mispred_cnt, e.c0, e.c1, e.c2);
        end
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int busy_seen;
    RSTn = 1'b0;
    rd_idx = '0; rd_tag = '0; upd_valid = 0; upd_idx = '0; upd_tag = '0;
    upd_target = '0; upd_taken = 0; flush = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RSTn = 1'b1;

    for (int i = 0; i < SETS; i++) look("reset_lookup", i, 0);

    commit("alloc_3_5", 3, 5, 32'h0000_1234, 1);
    look("hit_3_5", 3, 5);
    look("miss_3_6", 3, 6);

    for (int i = 0; i < 3; i++) begin
      commit("ctr_nt", 3, 5, 32'h0000_1234, 0);
      look("ctr_nt_look", 3, 5);
    end
    for (int i = 0; i < 5; i++) begin
      commit("ctr_tk", 3, 5, 32'h0000_1234, 1);
      look("ctr_tk_look", 3, 5);
    end
    commit("ctr_sat_nt", 3, 5, 32'h0000_1234, 0);
    look("ctr_sat_look", 3, 5);

    commit("lru_a1", 0, 1, 32'h0000_0100, 1);
    commit("lru_a2", 0, 2, 32'h0000_0200, 1);
    commit("lru_h1", 0, 1, 32'h0000_0111, 1);
    commit("lru_a3", 0, 3, 32'h0000_0300, 1);
    look("lru_t2_miss", 0, 2);
    look("lru_t1_hit", 0, 1);
    look("lru_t3_hit", 0, 3);
    commit("lru_nt4", 0, 4, 32'h0000_0400, 0);
    look("lru_t4_miss", 0, 4);

    step("flush_with_upd", 3, 5, 1, 9, 9, 32'hDEAD_0000, 1, 1);
    for (int i = 0; i < SETS + 2; i++)
      step("flush_busy", 3, 5, 1, i % SETS, 7, 32'h0000_7777, 1, i == 3);
    look("post_flush_3_5", 3, 5);
    look("post_flush_0_1", 0, 1);
    look("post_flush_0_3", 0, 3);
    look("post_flush_dropped", 2, 7);

    for (int i = 0; i < 600; i++) begin
      step("random",
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
           32'($urandom_range(0, 3)) * 32'h1000_0001,
           $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
    end

    // Drain any flush left over from the random phase.
    for (int i = 0; i < SETS + 1; i++) look("drain", i % SETS, 0);

    commit("pre_rst_alloc", 5, 9, 32'h0000_5555, 1);
    step("rst_flush", 5, 9, 0, 0, 0, 32'h0, 0, 1);
    busy_seen = 0;
    while (busy_seen < 4) begin
      look("rst_flush_busy", 5, 9);
      busy_seen++;
    end
    RSTn = 1'b0;
    model_reset();
    look("rst_mid_flush", 5, 9);
    RSTn = 1'b1;
    look("after_rst_miss", 5, 9);
    commit("after_rst_alloc", 7, 9, 32'h0000_ABCD, 1);
    look("after_rst_hit", 7, 9);
    for (int i = 0; i < 40; i++) begin
      step("random_post",
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
           32'($urandom_range(0, 3)) * 32'h0101_0101,
           $urandom_range(0, 1) != 0, 0);
    end

    chk_en = 1'b0;
    repeat (2) @(posedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
